// File: rtl/keccak_pad_absorb.sv
// rtl/keccak_pad_absorb.sv - Keccak pad10*1 padder and rate-block framer
// Streams a message in as words and emits rate-sized blocks with the padding merged in.
module keccak_pad_absorb #(
  parameter int BW_DATA    = 64,
  parameter int MAX_IBYTES = 1184,
  parameter int BW_IBLEN   = 11
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [BW_IBLEN-1:0] i_ibytes_len,
  input  logic [BW_DATA-1:0]  i_ibytes,
  input  logic                i_ibytes_valid,
  output logic                o_ibytes_ready,
  output logic [BW_DATA-1:0]  o_word,
  output logic                o_word_valid,
  input  logic                i_word_ready,
  output logic                o_blk_last,
  output logic                o_msg_last,
  output logic                o_busy,
  output logic                o_done
);
  localparam int NB = BW_DATA / 8;

  typedef logic [BW_IBLEN:0] off_t;
  typedef enum logic [1:0] {IDLE, DATA, PAD, DRAIN} state_e;

  function automatic logic [7:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    rate_of = 8'd136;
      2'd1:    rate_of = 8'd72;
      2'd2:    rate_of = 8'd168;
      default: rate_of = 8'd136;
    endcase
  endfunction

  state_e              state_q;
  logic [BW_IBLEN-1:0] len_q;
  off_t                off_q;
  logic [7:0]          rw_q, wib_q, ds_q;
  logic [BW_DATA-1:0]  word_q;
  logic                valid_q, blk_last_q, msg_last_q, busy_q, done_q;

  logic [BW_IBLEN-1:0] len_sat;
  off_t                off_end, len_x, pos;
  logic                can_adv, load, blk_last_d, msg_last_d, last_data;
  logic [BW_DATA-1:0]  word_d;
  logic [7:0]          b;

  always_comb begin
    len_sat    = (i_ibytes_len > BW_IBLEN'(MAX_IBYTES)) ? BW_IBLEN'(MAX_IBYTES) : i_ibytes_len;
    len_x      = {1'b0, len_q};
    off_end    = off_q + off_t'(NB);
    can_adv    = !valid_q || i_word_ready;
    o_ibytes_ready = (state_q == DATA) && can_adv;
    load       = ((state_q == PAD) && can_adv) || (o_ibytes_ready && i_ibytes_valid);
    blk_last_d = (wib_q == rw_q - 8'd1);
    // The final block is the one whose end lies beyond the message length.
    msg_last_d = blk_last_d && (off_end > len_x);
    last_data  = (off_end >= len_x);
    word_d     = '0;
    pos        = '0;
    b          = '0;
    for (int k = 0; k < NB; k++) begin
      pos = off_q + off_t'(k);
      b   = ((state_q == DATA) && (pos < len_x)) ? i_ibytes[8*k +: 8] : 8'h00;
      if (pos == len_x) b = b ^ ds_q;
      if (msg_last_d && (k == NB - 1)) b = b | 8'h80;
      word_d[8*k +: 8] = b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      off_q      <= '0;
      rw_q       <= '0;
      wib_q      <= '0;
      ds_q       <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      blk_last_q <= 1'b0;
      msg_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_q && i_word_ready) valid_q <= 1'b0;
      if (load) begin
        word_q     <= word_d;
        valid_q    <= 1'b1;
        blk_last_q <= blk_last_d;
        msg_last_q <= msg_last_d;
        off_q      <= off_end;
        wib_q      <= blk_last_d ? 8'd0 : wib_q + 8'd1;
      end
      case (state_q)
        IDLE: if (i_start) begin
          len_q   <= len_sat;
          rw_q    <= rate_of(i_mode) / 8'(NB);
          ds_q    <= i_mode[1] ? 8'h1F : 8'h06;
          off_q   <= '0;
          wib_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= (len_sat == '0) ? PAD : DATA;
        end
        DATA: if (load) begin
          if (msg_last_d)     state_q <= DRAIN;
          else if (last_data) state_q <= PAD;
        end
        PAD: if (load && msg_last_d) state_q <= DRAIN;
        DRAIN: if (valid_q && i_word_ready) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_blk_last   = blk_last_q;
  assign o_msg_last   = msg_last_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule
